// File: rtl/gpr_wb_pkg.sv
// gpr_wb_pkg: shared widths and the result-queue entry type for the GPR
// write-back unit.
//   REG_AW     - GPR address width (32 registers)
//   DATA_W     - GPR data width
//   CNT_W      - width of the head starvation counter (holds up to 15)
//   wb_entry_t - one pending memory result {valid, dst, data}; valid drops
//                when a newer ALU result to the same register overtakes it
// Optional feature macro used by the files that import this package:
//   GPR_WB_BYPASS_EN
package gpr_wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// gpr_wb_fifo: in-order queue of pending memory results with per-entry
// invalidation by destination register.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   push/push_dst/data   - append an entry at the tail (caller guarantees !full)
//   pop                  - drop the head entry (caller guarantees !empty)
//   inv_en/inv_dst       - clear valid on every stored entry with dst == inv_dst,
//                          including the entry being pushed in the same cycle
//   full, empty          - registered occupancy flags
//   head                 - entry at the read pointer
//   entries, rd_idx      - whole storage and head index, only present when
//                          GPR_WB_BYPASS_EN is defined (used for bypass lookup)
// Macro: GPR_WB_BYPASS_EN
module gpr_wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_AW-1:0] push_dst,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              inv_en,
    input  logic [REG_AW-1:0] inv_dst,
    output logic              full,
    output logic              empty,
    output wb_entry_t         head
`ifdef GPR_WB_BYPASS_EN
    ,
    output wb_entry_t [DEPTH-1:0]         entries,
    output logic [$clog2(DEPTH)-1:0]      rd_idx
`endif
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q;
    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_loc;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_loc = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_loc);
    assign head   = mem_q[rd_loc];

`ifdef GPR_WB_BYPASS_EN
    assign entries = mem_q;
    assign rd_idx  = rd_loc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (inv_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_q[i].dst == inv_dst) begin
                        mem_q[i].valid <= 1'b0;
                    end
                end
            end
            // Popped slots are cleared so only occupied slots can look valid.
            if (pop) begin
                mem_q[rd_loc].valid <= 1'b0;
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push) begin
                mem_q[wr_idx].valid <= !(inv_en && (push_dst == inv_dst));
                mem_q[wr_idx].dst   <= push_dst;
                mem_q[wr_idx].data  <= push_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_unit.sv
// gpr_wb_unit: arbitrates ALU and memory results onto the single GPR write
// port. ALU results go straight to the registered write port; memory results
// wait in gpr_wb_fifo. A queue head that waits STARVE_MAX cycles stalls the ALU
// for one cycle so it can drain.
// Handshakes: an ALU result is consumed when alu_valid && !alu_stall, and the
// upstream holds alu_* stable otherwise; a memory result is consumed when
// mem_valid && mem_ready, and mem_ready depends only on registered queue state.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   alu_valid/alu_dst/alu_data       - single-cycle result (youngest)
//   alu_stall                        - ALU result not consumed this cycle
//   mem_valid/mem_dst/mem_data       - multi-cycle result
//   mem_ready                        - queue has room
//   wb_we/wb_addr/wb_data            - registered GPR write port
//   lk_a/lk_b, lk_*_hit, lk_*_data   - pending-write bypass lookup
// Macro: GPR_WB_BYPASS_EN enables the lookup; otherwise lk_* outputs are 0.
module gpr_wb_unit
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] lk_a,
    input  logic [REG_AW-1:0] lk_b,
    output logic              lk_a_hit,
    output logic              lk_b_hit,
    output logic [DATA_W-1:0] lk_a_data,
    output logic [DATA_W-1:0] lk_b_data
);

    logic             q_full;
    logic             q_empty;
    wb_entry_t        q_head;
    logic             push;
    logic             pop;
    logic             alu_wr;
    logic [CNT_W-1:0] starve_cnt;

`ifdef GPR_WB_BYPASS_EN
    localparam int AW = $clog2(DEPTH);
    wb_entry_t [DEPTH-1:0] q_entries;
    logic [AW-1:0]         q_rd_idx;
`endif

    assign alu_stall = (starve_cnt == CNT_W'(STARVE_MAX));
    // A consumed ALU result to r0 is dropped and leaves the write slot free.
    assign alu_wr    = alu_valid && !alu_stall && (alu_dst != '0);
    assign mem_ready = !q_full;
    assign push      = mem_valid && !q_full && (mem_dst != '0);
    // An invalidated head never needs the write slot, so it leaves even while
    // the ALU is writing; a valid head waits for a free slot.
    assign pop       = !q_empty && (!q_head.valid || !alu_wr);

    gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dst  (mem_dst),
        .push_data (mem_data),
        .pop       (pop),
        .inv_en    (alu_wr),
        .inv_dst   (alu_dst),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
`ifdef GPR_WB_BYPASS_EN
        ,
        .entries   (q_entries),
        .rd_idx    (q_rd_idx)
`endif
    );

    // A non-popped head is always valid, so counting "not popped" is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (q_empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (alu_wr) begin
            wb_we   <= 1'b1;
            wb_addr <= alu_dst;
            wb_data <= alu_data;
        end else if (pop && q_head.valid) begin
            wb_we   <= 1'b1;
            wb_addr <= q_head.dst;
            wb_data <= q_head.data;
        end else begin
            wb_we   <= 1'b0;
        end
    end

`ifdef GPR_WB_BYPASS_EN
    // Youngest pending value wins: incoming ALU result, then the newest valid
    // queue entry (scan oldest to newest, last match kept), then the write port.
    function automatic logic [DATA_W:0] lookup(input logic [REG_AW-1:0] a);
        logic              hit;
        logic [DATA_W-1:0] d;
        logic [AW-1:0]     idx;
        hit = 1'b0;
        d   = '0;
        idx = '0;
        if (a != '0) begin
            if (alu_wr && (alu_dst == a)) begin
                hit = 1'b1;
                d   = alu_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    idx = q_rd_idx + AW'(i);
                    if (q_entries[idx].valid && (q_entries[idx].dst == a)) begin
                        hit = 1'b1;
                        d   = q_entries[idx].data;
                    end
                end
                if (!hit && wb_we && (wb_addr == a)) begin
                    hit = 1'b1;
                    d   = wb_data;
                end
            end
        end
        return {hit, d};
    endfunction

    assign {lk_a_hit, lk_a_data} = lookup(lk_a);
    assign {lk_b_hit, lk_b_data} = lookup(lk_b);
`else
    logic lk_unused;
    assign lk_unused = ^{lk_a, lk_b};
    assign lk_a_hit  = 1'b0;
    assign lk_b_hit  = 1'b0;
    assign lk_a_data = '0;
    assign lk_b_data = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_unit.sv
// tb_gpr_wb_unit: directed vector table, hand-written multi-cycle sequences
// and randomized traffic for gpr_wb_unit (DEPTH=4, STARVE_MAX=3), compared
// against a queue-based reference model of the write-back rules.
module tb_gpr_wb_unit;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_dst = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_dst = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  lk_a = '0;
    logic [4:0]  lk_b = '0;
    logic        lk_a_hit, lk_b_hit;
    logic [31:0] lk_a_data, lk_b_data;

    gpr_wb_unit #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lk_a(lk_a), .lk_b(lk_b),
        .lk_a_hit(lk_a_hit), .lk_b_hit(lk_b_hit), .lk_a_data(lk_a_data), .lk_b_data(lk_b_data)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- counters / check ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [4:0]  dst;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          write_cnt[32];
    logic        s_stall, s_ready;

    task automatic model_reset();
        mq.delete();
        m_cnt  = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

`ifdef GPR_WB_BYPASS_EN
    function automatic logic [32:0] m_lookup(input logic [4:0] a, input logic awr,
                                             input logic [4:0] ad, input logic [31:0] ax);
        logic [32:0] r;
        r = '0;
        if (a != 0) begin
            if (m_we && m_addr == a) r = {1'b1, m_data};
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].valid && mq[i].dst == a) r = {1'b1, mq[i].data};
            if (awr && ad == a) r = {1'b1, ax};
        end
        return r;
    endfunction
`endif

    // One clock of traffic: drive at negedge, check combinational outputs,
    // advance the model, then check the write port just after the rising edge.
    task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] ax,
                        input logic mv, input logic [4:0] md, input logic [31:0] mx,
                        input logic [4:0] la, input logic [4:0] lb);
        logic        e_stall, e_ready, awr, was_empty, popped;
        logic [32:0] ea, eb;
        ment_t       hd;
        @(negedge clk);
        alu_valid = av; alu_dst = ad; alu_data = ax;
        mem_valid = mv; mem_dst = md; mem_data = mx;
        lk_a = la; lk_b = lb;
        #1;
        e_stall = (m_cnt == SMAX);
        e_ready = (mq.size() < DEPTH);
        awr     = av && !e_stall && ad != 0;
        ea = '0;
        eb = '0;
`ifdef GPR_WB_BYPASS_EN
        ea = m_lookup(la, awr, ad, ax);
        eb = m_lookup(lb, awr, ad, ax);
`endif
        s_stall = alu_stall;
        s_ready = mem_ready;
        chk("alu_stall", 32'(alu_stall), 32'(e_stall));
        chk("mem_ready", 32'(mem_ready), 32'(e_ready));
        chk("lk_a_hit", 32'(lk_a_hit), 32'(ea[32]));
        chk("lk_a_data", lk_a_data, ea[31:0]);
        chk("lk_b_hit", 32'(lk_b_hit), 32'(eb[32]));
        chk("lk_b_data", lk_b_data, eb[31:0]);

        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        hd        = '{1'b0, 5'd0, 32'd0};
        if (!was_empty && (!mq[0].valid || !awr)) begin
            hd = mq.pop_front();
            popped = 1'b1;
        end
        if (awr)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].dst == ad) mq[i].valid = 1'b0;
        if (mv && e_ready && md != 0)
            mq.push_back('{!(awr && md == ad), md, mx});
        if (awr) begin
            m_we = 1'b1; m_addr = ad; m_data = ax;
        end else if (popped && hd.valid) begin
            m_we = 1'b1; m_addr = hd.dst; m_data = hd.data;
        end else begin
            m_we = 1'b0;
        end
        if (was_empty || popped) m_cnt = 0;
        else if (m_cnt < SMAX) m_cnt++;

        @(posedge clk);
        #1;
        chk("wb_we", 32'(wb_we), 32'(m_we));
        chk("wb_addr", 32'(wb_addr), 32'(m_addr));
        chk("wb_data", wb_data, m_data);
        if (wb_we) write_cnt[wb_addr]++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_alu_stall"}, 32'(alu_stall), 32'd0);
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] ax;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mx;
        logic [4:0]  lka;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic        av, mv, last_stall, last_ready, saw_full;
        logic [4:0]  ad, md;
        logic [31:0] ax, mx;
        int          k, c;

        //          av ad  ax            mv md  mx      lk stl rdy we addr data
        vecs[0]  = '{1, 5, 32'h12345678, 0, 0, 32'h0,  5, 0, 1, 1, 5, 32'h12345678};
        vecs[1]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'h55, 0, 0, 1, 0, 5, 32'h12345678};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1, 0, 5, 32'h12345678};
        vecs[3]  = '{0, 0, 32'h0,        1, 3, 32'hA,  3, 0, 1, 0, 5, 32'h12345678};
        vecs[4]  = '{0, 0, 32'h0,        1, 4, 32'hB,  3, 0, 1, 1, 3, 32'hA};
        vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,  4, 0, 1, 1, 4, 32'hB};
        vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1, 0, 4, 32'hB};
        vecs[7]  = '{0, 0, 32'h0,        1, 7, 32'h1,  7, 0, 1, 0, 4, 32'hB};
        vecs[8]  = '{1, 7, 32'h2,        0, 0, 32'h0,  7, 0, 1, 1, 7, 32'h2};
        vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,  7, 0, 1, 0, 7, 32'h2};
        vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1, 0, 7, 32'h2};
        vecs[11] = '{1, 1, 32'h11,       1, 9, 32'h99, 9, 0, 1, 1, 1, 32'h11};
        vecs[12] = '{1, 2, 32'h22,       0, 0, 32'h0,  9, 0, 1, 1, 2, 32'h22};
        vecs[13] = '{1, 3, 32'h33,       0, 0, 32'h0,  0, 0, 1, 1, 3, 32'h33};
        vecs[14] = '{1, 4, 32'h44,       0, 0, 32'h0,  0, 0, 1, 1, 4, 32'h44};
        vecs[15] = '{1, 5, 32'h55,       0, 0, 32'h0,  9, 1, 1, 1, 9, 32'h99};
        vecs[16] = '{1, 5, 32'h55,       0, 0, 32'h0,  0, 0, 1, 1, 5, 32'h55};

        for (int i = 0; i < 32; i++) write_cnt[i] = 0;
        model_reset();

        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // table
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].av, vecs[i].ad, vecs[i].ax, vecs[i].mv, vecs[i].md, vecs[i].mx,
                 vecs[i].lka, 5'd0);
            chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_data", i), wb_data, vecs[i].e_data);
        end
        chk("r0_never_written", 32'(write_cnt[0]), 32'd0);
        chk("r7_single_write", 32'(write_cnt[7]), 32'd1);

        // queue fill with continuous ALU traffic: five memory results r10..r14
        for (int i = 0; i < 32; i++) write_cnt[i] = 0;
        k = 0;
        c = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            step(1'b1, 5'(20 + c % 8), 32'(c), k < 5, 5'(10 + k), 32'hB0 + 32'(k),
                 5'(10 + cyc % 5), 5'(20 + cyc % 8));
            if (!s_stall) c++;
            if (!s_ready) saw_full = 1'b1;
            else if (k < 5) k++;
        end
        chk("fill_saw_full", 32'(saw_full), 32'd1);
        chk("fill_all_pushed", 32'(k), 32'd5);
        for (int r = 10; r < 15; r++)
            chk($sformatf("fill_r%0d_once", r), 32'(write_cnt[r]), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // reset with results still queued
        for (int i = 0; i < 32; i++) write_cnt[i] = 0;
        step(1'b1, 5'd20, 32'h20, 1'b1, 5'd15, 32'hF15, 5'd15, 5'd0);
        step(1'b1, 5'd21, 32'h21, 1'b1, 5'd16, 32'hF16, 5'd16, 5'd15);
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd15, 5'd16);
        chk("midreset_r15_dropped", 32'(write_cnt[15]), 32'd0);
        chk("midreset_r16_dropped", 32'(write_cnt[16]), 32'd0);

        // randomized traffic; upstream holds a result until it is consumed
        av = 1'b0; ad = '0; ax = '0;
        mv = 1'b0; md = '0; mx = '0;
        last_stall = 1'b0;
        last_ready = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!(av && last_stall)) begin
                av = ($urandom_range(0, 3) != 0);
                ad = 5'($urandom_range(0, 7));
                ax = $urandom;
            end
            if (!mv || last_ready) begin
                mv = ($urandom_range(0, 2) == 0);
                md = 5'($urandom_range(0, 7));
                mx = $urandom;
            end
            step(av, ad, ax, mv, md, mx, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            last_stall = s_stall;
            last_ready = s_ready;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
